boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 149 ++++++++++++++
 tb/tb_boot_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: holds the processor in boot mode and streams host words
// into the instruction cache, one write strobe per accepted word.
module boot_loader #(
   parameter int unsigned ARM_CYCLES  = 2,
   parameter int unsigned TAIL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        host_valid,
   input  logic [31:0] host_data,
   input  logic        host_last,
   output logic        host_ready,
   output logic        boot_up,
   output logic [7:0]  boot_addr,
   output logic [31:0] boot_datai,
   output logic        boot_web,
   output logic        load_done,
   output logic [8:0]  word_count,
   output logic        err_overflow
);

   localparam int unsigned CNT_MAX  = (ARM_CYCLES > TAIL_CYCLES) ? ARM_CYCLES : TAIL_CYCLES;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1) + 1;
   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WCNT_W   = 9;
   localparam int unsigned LAST_IDX = (1 << ADDR_W) - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_LOAD,
      S_TAIL,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic                up_q, up_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   datai_q, datai_d;
   logic                web_q, web_d;
   logic                done_q, done_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                ovf_q, ovf_d;
   logic                accept;

   // State and output registers; reset releases any write strobe immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         up_q    <= 1'b0;
         addr_q  <= '0;
         datai_q <= '0;
         web_q   <= 1'b1;
         done_q  <= 1'b0;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         up_q    <= up_d;
         addr_q  <= addr_d;
         datai_q <= datai_d;
         web_q   <= web_d;
         done_q  <= done_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and next-output logic; outputs are derived from the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      datai_d = datai_q;
      web_d   = 1'b1;
      done_d  = done_q;
      wcnt_d  = wcnt_q;
      ovf_d   = ovf_q;
      accept  = host_valid && ready_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_ARM;
               cnt_d   = '0;
               wcnt_d  = '0;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_ARM: begin
            if (32'(cnt_q) + 32'd1 >= ARM_CYCLES) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_LOAD: begin
            if (accept) begin
               web_d   = 1'b0;
               addr_d  = wcnt_q[ADDR_W-1:0];
               datai_d = host_data;
               wcnt_d  = wcnt_q + WCNT_W'(1);
               // Address 0xFF is the last slot; stop rather than wrap
               if (host_last || (32'(wcnt_q) == LAST_IDX)) begin
                  state_d = S_TAIL;
                  cnt_d   = '0;
                  if (!host_last) begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         S_TAIL: begin
            if (32'(cnt_q) >= TAIL_CYCLES) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      up_d    = (state_d == S_ARM) || (state_d == S_LOAD) || (state_d == S_TAIL);
      ready_d = (state_d == S_LOAD);
   end

   assign host_ready   = ready_q;
   assign boot_up      = up_q;
   assign boot_addr    = addr_q;
   assign boot_datai   = datai_q;
   assign boot_web     = web_q;
   assign load_done    = done_q;
   assign word_count   = wcnt_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader with a cycle-counting reference model.
module tb_boot_loader;

   localparam int unsigned ARM  = 2;
   localparam int unsigned TAIL = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        host_valid;
   logic [31:0] host_data;
   logic        host_last;
   logic        host_ready;
   logic        boot_up;
   logic [7:0]  boot_addr;
   logic [31:0] boot_datai;
   logic        boot_web;
   logic        load_done;
   logic [8:0]  word_count;
   logic        err_overflow;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_addr = 8'h00;
   logic [31:0] exp_data = 32'h0;

   always #5 clk = ~clk;

   boot_loader #(.ARM_CYCLES(ARM), .TAIL_CYCLES(TAIL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .host_valid   (host_valid),
      .host_data    (host_data),
      .host_last    (host_last),
      .host_ready   (host_ready),
      .boot_up      (boot_up),
      .boot_addr    (boot_addr),
      .boot_datai   (boot_datai),
      .boot_web     (boot_web),
      .load_done    (load_done),
      .word_count   (word_count),
      .err_overflow (err_overflow)
   );

   // Single comparison point: counts and reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_up"},   32'(boot_up),      32'd0);
      chk({tag, "_web"},  32'(boot_web),     32'd1);
      chk({tag, "_addr"}, 32'(boot_addr),    32'd0);
      chk({tag, "_data"}, boot_datai,        32'd0);
      chk({tag, "_rdy"},  32'(host_ready),   32'd0);
      chk({tag, "_done"}, 32'(load_done),    32'd0);
      chk({tag, "_cnt"},  32'(word_count),   32'd0);
      chk({tag, "_ovf"},  32'(err_overflow), 32'd0);
   endtask

   task automatic drive_junk();
      host_valid = 1'($urandom);
      host_data  = $urandom;
      host_last  = 1'($urandom);
   endtask

   // One complete load: n words, gap_pct chance of an idle host cycle,
   // optional host_last on the final word, optional abort after abort_at words,
   // optional spurious start pulses while busy.
   task automatic do_load(input int n, input int gap_pct, input bit use_last,
                          input int abort_at, input bit spurious);
      int          idx      = 0;
      bit          prev_acc = 0;
      bit          acc_last = 0;
      bit          v;
      logic [31:0] w;
      int          guard    = 0;

      start = 1'b1;
      drive_junk();
      @(negedge clk);
      start = 1'b0;

      // Arming: boot mode asserted, host not yet served, status cleared
      for (int k = 0; k < int'(ARM); k++) begin
         chk("arm_up",   32'(boot_up),      32'd1);
         chk("arm_rdy",  32'(host_ready),   32'd0);
         chk("arm_web",  32'(boot_web),     32'd1);
         chk("arm_cnt",  32'(word_count),   32'd0);
         chk("arm_done", 32'(load_done),    32'd0);
         chk("arm_ovf",  32'(err_overflow), 32'd0);
         drive_junk();
         start = spurious ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end

      // Loading: one strobe per accepted word, addresses count from 0
      forever begin
         chk("ld_rdy",  32'(host_ready), 32'd1);
         chk("ld_up",   32'(boot_up),    32'd1);
         chk("ld_web",  32'(boot_web),   prev_acc ? 32'd0 : 32'd1);
         chk("ld_addr", 32'(boot_addr),  32'(exp_addr));
         chk("ld_data", boot_datai,      exp_data);
         chk("ld_cnt",  32'(word_count), 32'(idx));
         if (abort_at > 0 && idx == abort_at) begin
            #1 rst = 1'b1;
            #1 chk_reset_vals("abort");
            exp_addr = 8'h00;
            exp_data = 32'h0;
            start    = 1'b0;
            @(negedge clk);
            chk_reset_vals("abort_hold");
            rst = 1'b0;
            host_valid = 1'b0;
            return;
         end
         v = ($urandom_range(99) >= 32'(gap_pct));
         w = $urandom;
         host_valid = v;
         host_data  = w;
         host_last  = v ? (use_last && idx == n - 1) : 1'($urandom);
         start      = spurious ? 1'($urandom) : 1'b0;
         @(negedge clk);
         prev_acc = v;
         if (v) begin
            exp_addr = 8'(idx);
            exp_data = w;
            idx++;
            if (use_last && idx == n) begin
               acc_last = 1;
               break;
            end
            if (idx == 256) break;
         end
         guard++;
         if (guard > 4000) begin
            chk("ld_timeout", 32'd0, 32'd1);
            start = 1'b0;
            return;
         end
      end

      // Tail: final strobe now, then boot mode held TAIL more cycles
      start = 1'b0;
      chk("tail_rdy",  32'(host_ready), 32'd0);
      chk("tail_up",   32'(boot_up),    32'd1);
      chk("tail_web",  32'(boot_web),   32'd0);
      chk("tail_addr", 32'(boot_addr),  32'(exp_addr));
      chk("tail_data", boot_datai,      exp_data);
      chk("tail_cnt",  32'(word_count), 32'(idx));
      drive_junk();
      @(negedge clk);
      for (int k = 0; k < int'(TAIL); k++) begin
         chk("tail2_up",   32'(boot_up),    32'd1);
         chk("tail2_web",  32'(boot_web),   32'd1);
         chk("tail2_rdy",  32'(host_ready), 32'd0);
         chk("tail2_addr", 32'(boot_addr),  32'(exp_addr));
         chk("tail2_data", boot_datai,      exp_data);
         drive_junk();
         @(negedge clk);
      end

      // Done: processor released, status sticky, host ignored
      for (int k = 0; k < 3; k++) begin
         chk("done_up",   32'(boot_up),      32'd0);
         chk("done_rdy",  32'(host_ready),   32'd0);
         chk("done_web",  32'(boot_web),     32'd1);
         chk("done_flag", 32'(load_done),    32'd1);
         chk("done_cnt",  32'(word_count),   32'(idx));
         chk("done_ovf",  32'(err_overflow), acc_last ? 32'd0 : 32'd1);
         chk("done_addr", 32'(boot_addr),    32'(exp_addr));
         drive_junk();
         @(negedge clk);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      host_valid = 1'b0;
      host_data  = 32'h0;
      host_last  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      rst = 1'b0;

      do_load(4,   0,  1, 0, 0);   // basic back-to-back
      do_load(3,   70, 1, 0, 0);   // host stalls
      do_load(1,   0,  1, 0, 0);   // single word
      do_load(256, 20, 0, 0, 1);   // overflow with spurious starts
      do_load(10,  0,  1, 5, 0);   // reset mid-load after 5 words
      do_load(2,   0,  1, 0, 0);   // load right after reset release
      for (int i = 0; i < 6; i++) begin
         do_load(int'($urandom_range(40, 1)), int'($urandom_range(60, 0)), 1, 0, 1);
      end
      do_load(256, 0,  1, 0, 0);   // full 256 with last: no overflow

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
